// File: rtl/multi_acc_calculator.sv
// Bank of NUM_ACC accumulators driven by edge-triggered ALU commands,
// with a shared undo history, carry/zero flags and done/err pulses.
module multi_acc_calculator #(
  parameter int WIDTH      = 8,
  parameter int OPW        = 4,
  parameter int NUM_ACC    = 4,
  parameter int HIST_DEPTH = 4,
  parameter int SATURATE   = 0,
  localparam int ASW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1,
  localparam int HCW = $clog2(HIST_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [OPW-1:0]   operand,
  input  logic [ASW-1:0]   acc_sel,
  output logic [WIDTH-1:0] acc_out,
  output logic             done,
  output logic             err,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic [HCW-1:0]   hist_count
);

  localparam int HPW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam logic [HPW-1:0] HP_LAST = HPW'(HIST_DEPTH - 1);
  localparam logic [HCW-1:0] HC_FULL = HCW'(HIST_DEPTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_UNDO = 3'b111;

  logic [WIDTH-1:0] acc_q  [NUM_ACC];
  logic [WIDTH-1:0] acc_d  [NUM_ACC];
  logic [ASW-1:0]   hidx_q [HIST_DEPTH];
  logic [ASW-1:0]   hidx_d [HIST_DEPTH];
  logic [WIDTH-1:0] hval_q [HIST_DEPTH];
  logic [WIDTH-1:0] hval_d [HIST_DEPTH];
  logic [HPW-1:0]   wp_q, wp_d;
  logic [HCW-1:0]   hcnt_q, hcnt_d;
  logic             en_prev_q, en_prev_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic             sel_ok;
  logic [WIDTH-1:0] a, b, r;
  logic             c;
  logic [WIDTH:0]   sum, diff;
  logic [2*WIDTH-1:0] shl_w, shr_w;
  logic             b_big;
  logic [HPW-1:0]   top;

  assign sel_ok = (int'(acc_sel) < NUM_ACC);

  always_comb begin
    a     = sel_ok ? acc_q[acc_sel] : '0;
    b     = WIDTH'(operand);
    b_big = (32'(operand) >= WIDTH);
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    shl_w = {{WIDTH{1'b0}}, a} << b;
    shr_w = {a, {WIDTH{1'b0}}} >> b;
    r     = '0;
    c     = 1'b0;
    case (op)
      OP_ADD: begin
        c = sum[WIDTH];
        r = (SATURATE != 0 && c) ? '1 : sum[WIDTH-1:0];
      end
      OP_SUB: begin
        c = diff[WIDTH];
        r = (SATURATE != 0 && c) ? '0 : diff[WIDTH-1:0];
      end
      OP_XOR: r = a ^ b;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      // A shift of WIDTH or more discards every bit of a.
      OP_SHL: begin
        r = b_big ? '0 : shl_w[WIDTH-1:0];
        c = b_big ? (a != '0) : (shl_w[2*WIDTH-1:WIDTH] != '0);
      end
      OP_SHR: begin
        r = b_big ? '0 : shr_w[2*WIDTH-1:WIDTH];
        c = b_big ? (a != '0) : (shr_w[WIDTH-1:0] != '0);
      end
      default: ;
    endcase
  end

  assign top = (wp_q == '0) ? HP_LAST : wp_q - 1'b1;

  always_comb begin
    acc_d     = acc_q;
    hidx_d    = hidx_q;
    hval_d    = hval_q;
    wp_d      = wp_q;
    hcnt_d    = hcnt_q;
    en_prev_d = en;
    done_d    = 1'b0;
    err_d     = 1'b0;
    carry_d   = carry_q;
    zero_d    = zero_q;
    if (en && !en_prev_q) begin
      if (op == OP_UNDO) begin
        if (hcnt_q == '0) begin
          err_d = 1'b1;
        end else begin
          acc_d[hidx_q[top]] = hval_q[top];
          zero_d  = (hval_q[top] == '0);
          carry_d = 1'b0;
          wp_d    = top;
          hcnt_d  = hcnt_q - 1'b1;
          done_d  = 1'b1;
        end
      end else if (!sel_ok) begin
        err_d = 1'b1;
      end else begin
        acc_d[acc_sel] = r;
        zero_d  = (r == '0);
        carry_d = c;
        // Push overwrites the oldest entry once the ring is full.
        hidx_d[wp_q] = acc_sel;
        hval_d[wp_q] = a;
        wp_d    = (wp_q == HP_LAST) ? '0 : wp_q + 1'b1;
        hcnt_d  = (hcnt_q == HC_FULL) ? hcnt_q : hcnt_q + 1'b1;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q     <= '{default: '0};
      hidx_q    <= '{default: '0};
      hval_q    <= '{default: '0};
      wp_q      <= '0;
      hcnt_q    <= '0;
      en_prev_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      hidx_q    <= hidx_d;
      hval_q    <= hval_d;
      wp_q      <= wp_d;
      hcnt_q    <= hcnt_d;
      en_prev_q <= en_prev_d;
      done_q    <= done_d;
      err_q     <= err_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
    end
  end

  assign acc_out    = sel_ok ? acc_q[acc_sel] : '0;
  assign done       = done_q;
  assign err        = err_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign hist_count = hcnt_q;

endmodule

// File: tb/tb_multi_acc_calculator.sv
// Directed bench for multi_acc_calculator: a wrapping and a saturating
// instance share the same command stream.
module tb_multi_acc_calculator;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, XOR_ = 3'b010, SHL = 3'b011;
  localparam logic [2:0] SHR = 3'b100, AND_ = 3'b101, OR_ = 3'b110, UNDO = 3'b111;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [2:0] op = 3'b000;
  logic [3:0] operand = 4'd0;
  logic [1:0] acc_sel = 2'd0;

  logic [7:0] acc_w, acc_s;
  logic       done_w, err_w, carry_w, zero_w;
  logic       done_s, err_s, carry_s, zero_s;
  logic [2:0] hist_w, hist_s;

  int n_assert = 0;
  int n_fail   = 0;
  int dcnt;

  always #5 clock = ~clock;

  multi_acc_calculator #(.SATURATE(0)) dut (
    .clock(clock), .reset(reset), .en(en), .op(op), .operand(operand),
    .acc_sel(acc_sel), .acc_out(acc_w), .done(done_w), .err(err_w),
    .carry_flag(carry_w), .zero_flag(zero_w), .hist_count(hist_w));

  multi_acc_calculator #(.SATURATE(1)) dut_sat (
    .clock(clock), .reset(reset), .en(en), .op(op), .operand(operand),
    .acc_sel(acc_sel), .acc_out(acc_s), .done(done_s), .err(err_s),
    .carry_flag(carry_s), .zero_flag(zero_s), .hist_count(hist_s));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    en    = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Raise en for one cycle; returns at the negedge where done/err are visible.
  task automatic cmd(input logic [2:0] o, input logic [3:0] v, input logic [1:0] s);
    @(negedge clock);
    op = o; operand = v; acc_sel = s; en = 1'b1;
    @(negedge clock);
    en = 1'b0;
  endtask

  task automatic load(input logic [1:0] s, input logic [7:0] val);
    cmd(OR_, val[7:4], s);
    cmd(SHL, 4'd4, s);
    cmd(OR_, val[3:0], s);
  endtask

  initial begin
    // 1: reset state, then one ADD with en held high for 10 cycles
    do_reset();
    @(negedge clock);
    chk("rst_acc", acc_w, 0);
    chk("rst_done", done_w, 0);
    chk("rst_err", err_w, 0);
    chk("rst_carry", carry_w, 0);
    chk("rst_zero", zero_w, 0);
    chk("rst_hist", hist_w, 0);
    op = ADD; operand = 4'd5; acc_sel = 2'd0; en = 1'b1;
    @(negedge clock);
    chk("hold_done", done_w, 1);
    chk("hold_acc", acc_w, 5);
    chk("hold_zero", zero_w, 0);
    chk("hold_hist", hist_w, 1);
    dcnt = 0;
    repeat (9) begin
      @(negedge clock);
      dcnt += int'(done_w);
    end
    chk("hold_done_once", dcnt, 0);
    chk("hold_acc_after", acc_w, 5);
    chk("hold_hist_after", hist_w, 1);
    en = 1'b0;

    // 2: 250 + 9 wraps / saturates
    do_reset();
    load(2'd0, 8'd250);
    chk("load250", acc_w, 250);
    cmd(ADD, 4'd9, 2'd0);
    chk("add_wrap_acc", acc_w, 3);
    chk("add_wrap_carry", carry_w, 1);
    chk("add_sat_acc", acc_s, 255);
    chk("add_sat_carry", carry_s, 1);
    chk("add_hist_full", hist_w, 4);

    // 3: 3 - 7 borrows
    do_reset();
    cmd(ADD, 4'd3, 2'd2);
    cmd(SUB, 4'd7, 2'd2);
    chk("sub_wrap_acc", acc_w, 252);
    chk("sub_wrap_carry", carry_w, 1);
    chk("sub_wrap_zero", zero_w, 0);
    chk("sub_sat_acc", acc_s, 0);
    chk("sub_sat_carry", carry_s, 1);
    chk("sub_sat_zero", zero_s, 1);

    // 4: shifts and logic ops on acc1
    do_reset();
    load(2'd1, 8'h81);
    chk("load81", acc_w, 8'h81);
    cmd(SHL, 4'd8, 2'd1);
    chk("shl8_acc", acc_w, 0);
    chk("shl8_carry", carry_w, 1);
    chk("shl8_zero", zero_w, 1);
    cmd(OR_, 4'hF, 2'd1);
    cmd(SHR, 4'd3, 2'd1);
    chk("shr3_acc", acc_w, 1);
    chk("shr3_carry", carry_w, 1);
    chk("shr3_zero", zero_w, 0);
    cmd(XOR_, 4'd3, 2'd1);
    chk("xor_acc", acc_w, 2);
    chk("xor_carry", carry_w, 0);
    cmd(AND_, 4'd6, 2'd1);
    chk("and_acc", acc_w, 2);
    cmd(OR_, 4'd5, 2'd1);
    chk("or_acc", acc_w, 7);
    cmd(SHL, 4'd1, 2'd1);
    chk("shl1_acc", acc_w, 8'h0E);
    chk("shl1_carry", carry_w, 0);
    cmd(SHR, 4'd1, 2'd1);
    chk("shr1_acc", acc_w, 7);
    chk("shr1_carry", carry_w, 0);

    // 5: undo history on acc3
    do_reset();
    repeat (5) cmd(ADD, 4'd1, 2'd3);
    chk("undo_pre_acc", acc_w, 5);
    chk("undo_pre_hist", hist_w, 4);
    for (int i = 0; i < 4; i++) begin
      cmd(UNDO, 4'd0, 2'd0);
      acc_sel = 2'd3;
      #1;
      chk("undo_acc", acc_w, 32'(4 - i));
      chk("undo_hist", hist_w, 32'(3 - i));
      chk("undo_done", done_w, 1);
    end
    chk("undo_zero", zero_w, 0);
    chk("undo_carry", carry_w, 0);
    cmd(UNDO, 4'd0, 2'd3);
    chk("undo_empty_err", err_w, 1);
    chk("undo_empty_done", done_w, 0);
    chk("undo_empty_acc", acc_w, 1);
    chk("undo_empty_hist", hist_w, 0);
    @(negedge clock);
    chk("undo_err_pulse", err_w, 0);

    // 6: en high through reset
    do_reset();
    cmd(ADD, 4'd4, 2'd0);
    chk("pre_rst_acc", acc_w, 4);
    @(negedge clock);
    reset = 1'b1;
    op = ADD; operand = 4'd2; acc_sel = 2'd0; en = 1'b1;
    @(negedge clock);
    chk("midrst_acc", acc_w, 0);
    chk("midrst_hist", hist_w, 0);
    chk("midrst_done", done_w, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("postrst_done", done_w, 1);
    chk("postrst_acc", acc_w, 2);
    chk("postrst_hist", hist_w, 1);
    @(negedge clock);
    chk("postrst_once", done_w, 0);
    en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
